// File: rtl/tmds_pkg.sv
// -----------------------------------------------------------------------------
// tmds_pkg
// Shared definitions for the TMDS receive word aligner:
//   - CTRL_TOKEN_00/01/10/11 : the four 10-bit TMDS control tokens (c1c0 = suffix)
//   - tmds_rx_state_t        : aligner FSM state (ST_SEARCH, ST_LOCKED)
//   - tmds_sym_t             : one 10-bit TMDS symbol
//   - WORD_W / OFFSET_MAX    : raw RX word width and highest legal slip offset
//   - cnt_w()                : counter width for a terminal count, never below 1
// -----------------------------------------------------------------------------
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'h354;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'h0AB;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'h154;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'h2AB;

  localparam int WORD_W     = 20;
  localparam int OFFSET_MAX = WORD_W - 1;

  typedef enum logic [0:0] {ST_SEARCH, ST_LOCKED} tmds_rx_state_t;

  typedef logic [9:0] tmds_sym_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tmds_rx_word_aligner_if.sv
// -----------------------------------------------------------------------------
// tmds_rx_word_aligner_if
// Bundles the RX-lane input side and the aligned-symbol output side of one
// aligner instance.
//   rx_ready    : GTH RX reset done; low restarts the search
//   rx_data     : raw 20-bit RX word, bit 0 earliest
//   sym0/sym1   : aligned symbols (sym0 earlier in time)
//   sym_valid   : sym0/sym1 qualifier, equal to locked
//   ctrl_valid  : per-symbol control-token flag (bit0 = sym0)
//   ctrl_code   : {c1c0 of sym1, c1c0 of sym0}
//   locked      : alignment acquired
//   bit_offset  : current slip offset 0..19
//   state       : aligner FSM state, exposed for debug/checkers
//   loss_count  : lock-loss counter, only when TMDS_RX_STATS_EN is defined
// Handshake: there is no backpressure. rx_data is accepted every clock while
// rx_ready is high; sym0/sym1 are produced every clock and are meaningful only
// in cycles where sym_valid is high.
// Modports: master = the aligner (consumes rx side, drives symbol side);
//           slave  = the surrounding lane logic (drives rx side, consumes symbols).
// -----------------------------------------------------------------------------
interface tmds_rx_word_aligner_if;
  import tmds_pkg::*;

  logic           rx_ready;
  logic [19:0]    rx_data;
  tmds_sym_t      sym0;
  tmds_sym_t      sym1;
  logic           sym_valid;
  logic [1:0]     ctrl_valid;
  logic [3:0]     ctrl_code;
  logic           locked;
  logic [4:0]     bit_offset;
  tmds_rx_state_t state;
`ifdef TMDS_RX_STATS_EN
  logic [15:0]    loss_count;
`endif

  modport master (
    input  rx_ready, rx_data,
    output sym0, sym1, sym_valid, ctrl_valid, ctrl_code, locked, bit_offset, state
`ifdef TMDS_RX_STATS_EN
    , output loss_count
`endif
  );

  modport slave (
    output rx_ready, rx_data,
    input  sym0, sym1, sym_valid, ctrl_valid, ctrl_code, locked, bit_offset, state
`ifdef TMDS_RX_STATS_EN
    , input loss_count
`endif
  );

endinterface

// File: rtl/tmds_ctrl_detect.sv
// -----------------------------------------------------------------------------
// tmds_ctrl_detect
// Combinational TMDS control-token recogniser.
//   i_sym     : 10-bit candidate symbol
//   o_is_ctrl : high when i_sym is one of the four control tokens
//   o_code    : c1c0 of the token, 0 when i_sym is not a control token
// -----------------------------------------------------------------------------
module tmds_ctrl_detect
  import tmds_pkg::*;
(
  input  tmds_sym_t  i_sym,
  output logic       o_is_ctrl,
  output logic [1:0] o_code
);

  always_comb begin
    o_is_ctrl = 1'b1;
    o_code    = 2'b00;
    case (i_sym)
      CTRL_TOKEN_00: o_code = 2'b00;
      CTRL_TOKEN_01: o_code = 2'b01;
      CTRL_TOKEN_10: o_code = 2'b10;
      CTRL_TOKEN_11: o_code = 2'b11;
      default: begin
        o_is_ctrl = 1'b0;
        o_code    = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/tmds_rx_word_aligner.sv
// -----------------------------------------------------------------------------
// tmds_rx_word_aligner
// Finds the 10-bit symbol boundary in a 20-bit GTH RX word stream by hunting
// for words made of two TMDS control tokens, then delivers two aligned symbols
// per clock with their decoded control codes.
// Ports:
//   clk    : RX word clock
//   resetn : asynchronous active-low reset
//   bus    : tmds_rx_word_aligner_if.master (rx side in, symbol side out)
// Parameters:
//   LOCK_COUNT    : consecutive control words needed to lock
//   SEARCH_CYCLES : cycles spent per offset before slipping one bit
//   LOSS_CYCLES   : cycles without a control word before lock is dropped
// Optional feature: define TMDS_RX_STATS_EN to add the 16-bit saturating
// loss_count (lock drops caused by loss timeout only).
// -----------------------------------------------------------------------------
module tmds_rx_word_aligner
  import tmds_pkg::*;
#(
  parameter int LOCK_COUNT    = 8,
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic                   clk,
  input  logic                   resetn,
  tmds_rx_word_aligner_if.master bus
);

  localparam int HIT_W  = cnt_w(LOCK_COUNT);
  localparam int TMO_W  = cnt_w(SEARCH_CYCLES);
  localparam int LOSS_W = cnt_w(LOSS_CYCLES);

  localparam logic [HIT_W-1:0]  HIT_LAST  = HIT_W'(LOCK_COUNT - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(SEARCH_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);

  tmds_rx_state_t     r_state,  w_state_nxt;
  logic [4:0]         r_offset, w_offset_nxt;
  logic [HIT_W-1:0]   r_hit,    w_hit_nxt;
  logic [TMO_W-1:0]   r_tmo,    w_tmo_nxt;
  logic [LOSS_W-1:0]  r_loss,   w_loss_nxt;
  logic [19:0]        r_prev;

  tmds_sym_t          r_sym0, r_sym1;
  logic [1:0]         r_ctrl_valid;
  logic [3:0]         r_ctrl_code;

  // Sliding window over the last two words; bit 0 of the window is the
  // earliest bit, so offset 0 presents the previous word unchanged.
  logic [39:0]        w_cat;
  logic [5:0]         w_sel;
  logic [19:0]        w_win;
  logic               w_ctrl0, w_ctrl1, w_ctrl_word;
  logic [1:0]         w_code0, w_code1;

  assign w_cat = {bus.rx_data, r_prev};
  assign w_sel = {1'b0, r_offset};
  assign w_win = w_cat[w_sel +: 20];

  tmds_ctrl_detect u_det0 (
    .i_sym     (w_win[9:0]),
    .o_is_ctrl (w_ctrl0),
    .o_code    (w_code0)
  );

  tmds_ctrl_detect u_det1 (
    .i_sym     (w_win[19:10]),
    .o_is_ctrl (w_ctrl1),
    .o_code    (w_code1)
  );

  assign w_ctrl_word = w_ctrl0 & w_ctrl1;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= ST_SEARCH;
      r_offset <= '0;
      r_hit    <= '0;
      r_tmo    <= '0;
      r_loss   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_offset <= w_offset_nxt;
      r_hit    <= w_hit_nxt;
      r_tmo    <= w_tmo_nxt;
      r_loss   <= w_loss_nxt;
    end
  end

  // Counters stop at their terminal compare, so none of them can wrap.
  always_comb begin
    w_state_nxt  = r_state;
    w_offset_nxt = r_offset;
    w_hit_nxt    = r_hit;
    w_tmo_nxt    = r_tmo;
    w_loss_nxt   = r_loss;
    if (!bus.rx_ready) begin
      w_state_nxt  = ST_SEARCH;
      w_offset_nxt = '0;
      w_hit_nxt    = '0;
      w_tmo_nxt    = '0;
      w_loss_nxt   = '0;
    end else begin
      case (r_state)
        ST_SEARCH: begin
          // Lock is tested first so it wins over a coincident slip timeout.
          if (w_ctrl_word && (r_hit == HIT_LAST)) begin
            w_state_nxt = ST_LOCKED;
            w_hit_nxt   = '0;
            w_tmo_nxt   = '0;
            w_loss_nxt  = '0;
          end else begin
            w_hit_nxt = w_ctrl_word ? (r_hit + HIT_W'(1)) : '0;
            if (r_tmo == TMO_LAST) begin
              w_offset_nxt = (r_offset == 5'(OFFSET_MAX)) ? 5'd0 : (r_offset + 5'd1);
              w_hit_nxt    = '0;
              w_tmo_nxt    = '0;
            end else begin
              w_tmo_nxt = r_tmo + TMO_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          // A control word on the expiry cycle still refreshes the timer.
          if (w_ctrl_word) begin
            w_loss_nxt = '0;
          end else if (r_loss == LOSS_LAST) begin
            w_state_nxt = ST_SEARCH;
            w_hit_nxt   = '0;
            w_tmo_nxt   = '0;
            w_loss_nxt  = '0;
          end else begin
            w_loss_nxt = r_loss + LOSS_W'(1);
          end
        end
        default: w_state_nxt = ST_SEARCH;
      endcase
    end
  end

  // prev is zeroed while rx_ready is low so a restarted search never sees
  // stale bits from before the transceiver reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_prev       <= '0;
      r_sym0       <= '0;
      r_sym1       <= '0;
      r_ctrl_valid <= '0;
      r_ctrl_code  <= '0;
    end else begin
      r_prev       <= bus.rx_ready ? bus.rx_data : 20'd0;
      r_sym0       <= w_win[9:0];
      r_sym1       <= w_win[19:10];
      r_ctrl_valid <= {w_ctrl1, w_ctrl0};
      r_ctrl_code  <= {w_code1, w_code0};
    end
  end

  assign bus.sym0       = r_sym0;
  assign bus.sym1       = r_sym1;
  assign bus.ctrl_valid = r_ctrl_valid;
  assign bus.ctrl_code  = r_ctrl_code;
  assign bus.locked     = (r_state == ST_LOCKED);
  assign bus.sym_valid  = (r_state == ST_LOCKED);
  assign bus.bit_offset = r_offset;
  assign bus.state      = r_state;

`ifdef TMDS_RX_STATS_EN
  // With rx_ready high, the only LOCKED->SEARCH path is the loss timeout.
  logic        w_loss_evt;
  logic [15:0] r_loss_count;

  assign w_loss_evt = bus.rx_ready && (r_state == ST_LOCKED) && (w_state_nxt == ST_SEARCH);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_loss_count <= '0;
    end else if (w_loss_evt && (r_loss_count != 16'hFFFF)) begin
      r_loss_count <= r_loss_count + 16'd1;
    end
  end

  assign bus.loss_count = r_loss_count;
`endif

endmodule

// File: tb/tb_tmds_rx_word_aligner.sv
module tb_tmds_rx_word_aligner;
  import tmds_pkg::*;

  localparam int LOCK_COUNT    = 8;
  localparam int SEARCH_CYCLES = 2048;
  localparam int LOSS_CYCLES   = 4096;
  localparam int W             = 49;

  localparam logic [19:0] WORD_ALIGNED = {10'h0AB, 10'h354};
  localparam logic [19:0] WORD_DATA    = {10'h1F0, 10'h1F0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  tmds_rx_word_aligner_if bus();

  tmds_rx_word_aligner #(
    .LOCK_COUNT   (LOCK_COUNT),
    .SEARCH_CYCLES(SEARCH_CYCLES),
    .LOSS_CYCLES  (LOSS_CYCLES)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  logic        m_locked;
  int          m_off, m_hit, m_tmo, m_loss, m_loss_count;
  logic [19:0] m_prev;
  logic [19:0] word_rot7;

  function automatic logic [2:0] tok(input logic [9:0] s);
    case (s)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 1'b0; m_off = 0; m_hit = 0; m_tmo = 0; m_loss = 0;
    m_loss_count = 0; m_prev = '0;
    exp_q.delete();
  endtask

  task automatic model_push(input logic rdy, input logic [19:0] d);
    logic [39:0] cat;
    logic [19:0] w;
    logic [5:0]  sel;
    logic [2:0]  t0, t1;
    logic        cw;
    int          old_tmo;
    cat = {d, m_prev};
    sel = 6'(m_off);
    w   = cat[sel +: 20];
    t0  = tok(w[9:0]);
    t1  = tok(w[19:10]);
    cw  = t0[2] & t1[2];
    if (!rdy) begin
      m_locked = 1'b0; m_off = 0; m_hit = 0; m_tmo = 0; m_loss = 0; m_prev = '0;
    end else begin
      m_prev = d;
      if (!m_locked) begin
        old_tmo = m_tmo;
        m_hit = cw ? m_hit + 1 : 0;
        if (m_hit == LOCK_COUNT) begin
          m_locked = 1'b1; m_hit = 0; m_tmo = 0; m_loss = 0;
        end else if (old_tmo == SEARCH_CYCLES - 1) begin
          m_off = (m_off + 1) % 20; m_hit = 0; m_tmo = 0;
        end else begin
          m_tmo = old_tmo + 1;
        end
      end else begin
        if (cw) m_loss = 0;
        else if (m_loss == LOSS_CYCLES - 1) begin
          m_locked = 1'b0; m_loss = 0; m_hit = 0; m_tmo = 0;
`ifdef TMDS_RX_STATS_EN
          if (m_loss_count < 65535) m_loss_count = m_loss_count + 1;
`endif
        end else m_loss = m_loss + 1;
      end
    end
    exp_q.push_back({16'(m_loss_count), m_locked, m_locked, 5'(m_off), w[19:10], w[9:0],
                     t1[2], t0[2], t1[1:0], t0[1:0]});
  endtask

  // ---------------- driver + scoreboard ----------------
  task automatic cycle(input logic rdy, input logic [19:0] d);
    logic [W-1:0] exp_v, act_v;
    logic [15:0]  act_lc;
    bus.rx_ready = rdy;
    bus.rx_data  = d;
    model_push(rdy, d);
    @(posedge clk);
    #1;
`ifdef TMDS_RX_STATS_EN
    act_lc = bus.loss_count;
`else
    act_lc = 16'h0;
`endif
    act_v = {act_lc, bus.locked, bus.sym_valid, bus.bit_offset, bus.sym1, bus.sym0,
             bus.ctrl_valid, bus.ctrl_code};
    exp_v = exp_q.pop_front();
    n_vec++;
    if (act_v !== exp_v) begin
      n_err++;
      $display("FAIL scoreboard t=%0t: got %h want %h", $time, act_v, exp_v);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    bus.rx_ready = 1'b0;
    bus.rx_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.locked, bus.sym_valid, bus.bit_offset, bus.sym0, bus.sym1, bus.ctrl_valid, bus.ctrl_code} !== 33'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b/%b/%0d/%h/%h/%b/%b want all zero", bus.locked, bus.sym_valid,
               bus.bit_offset, bus.sym0, bus.sym1, bus.ctrl_valid, bus.ctrl_code);
    end
    n_vec++;
    if (bus.state !== ST_SEARCH) begin
      n_err++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_SEARCH);
    end
`ifdef TMDS_RX_STATS_EN
    n_vec++;
    if (bus.loss_count !== 16'd0) begin
      n_err++; $display("FAIL reset_loss_count: got %0d want 0", bus.loss_count);
    end
`endif
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) cycle(1'b0, 20'd0);
  endtask

  task automatic test_aligned();
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, WORD_ALIGNED);
      if (i == 8) begin
        n_vec++;
        if (bus.locked !== 1'b0) begin n_err++; $display("FAIL aligned_early: locked=%b want 0", bus.locked); end
      end
      if (i == 9) begin
        n_vec++;
        if (bus.locked !== 1'b1 || bus.sym_valid !== 1'b1) begin
          n_err++; $display("FAIL aligned_lock: locked=%b sym_valid=%b want 1/1", bus.locked, bus.sym_valid);
        end
        n_vec++;
        if (bus.bit_offset !== 5'd0 || bus.ctrl_code !== 4'b0100 || bus.ctrl_valid !== 2'b11) begin
          n_err++; $display("FAIL aligned_code: off=%0d code=%b cv=%b want 0/0100/11", bus.bit_offset, bus.ctrl_code, bus.ctrl_valid);
        end
      end
    end
  endtask

  task automatic test_rotated();
    int lock_at;
    lock_at = 7 * SEARCH_CYCLES + LOCK_COUNT;
    cycle(1'b0, word_rot7);
    for (int i = 1; i <= lock_at; i++) begin
      cycle(1'b1, word_rot7);
      if (i == SEARCH_CYCLES - 1 || i == SEARCH_CYCLES) begin
        n_vec++;
        if (bus.bit_offset !== ((i == SEARCH_CYCLES) ? 5'd1 : 5'd0)) begin
          n_err++; $display("FAIL rotated_slip: cycle %0d offset=%0d", i, bus.bit_offset);
        end
      end
      if (i == lock_at - 1) begin
        n_vec++;
        if (bus.locked !== 1'b0 || bus.bit_offset !== 5'd7) begin
          n_err++; $display("FAIL rotated_early: locked=%b off=%0d want 0/7", bus.locked, bus.bit_offset);
        end
      end
    end
    n_vec++;
    if (bus.locked !== 1'b1 || bus.bit_offset !== 5'd7) begin
      n_err++; $display("FAIL rotated_lock: locked=%b off=%0d want 1/7", bus.locked, bus.bit_offset);
    end
    n_vec++;
    if (bus.sym0 !== 10'h354 || bus.sym1 !== 10'h0AB) begin
      n_err++; $display("FAIL rotated_syms: sym0=%h sym1=%h want 354/0ab", bus.sym0, bus.sym1);
    end
  endtask

  task automatic test_sparse_ctrl();
    logic held;
    held = 1'b1;
    for (int i = 1; i <= 20000; i++) begin
      cycle(1'b1, ((i % 1000) >= 998) ? word_rot7 : WORD_DATA);
      held = held & bus.locked;
    end
    n_vec++;
    if (held !== 1'b1) begin n_err++; $display("FAIL sparse_hold: held=%b want 1", held); end
  endtask

  task automatic test_loss();
    repeat (2) cycle(1'b1, word_rot7);
    for (int i = 1; i <= LOSS_CYCLES; i++) begin
      cycle(1'b1, WORD_DATA);
      if (i == LOSS_CYCLES - 1) begin
        n_vec++;
        if (bus.locked !== 1'b1) begin n_err++; $display("FAIL loss_early: locked=%b want 1", bus.locked); end
      end
    end
    n_vec++;
    if (bus.locked !== 1'b0 || bus.sym_valid !== 1'b0 || bus.bit_offset !== 5'd7) begin
      n_err++; $display("FAIL loss_drop: locked=%b sym_valid=%b off=%0d want 0/0/7", bus.locked, bus.sym_valid, bus.bit_offset);
    end
`ifdef TMDS_RX_STATS_EN
    n_vec++;
    if (bus.loss_count !== 16'd1) begin n_err++; $display("FAIL loss_count: got %0d want 1", bus.loss_count); end
`endif
  endtask

  task automatic test_rx_ready_drop();
    repeat (LOCK_COUNT + 1) cycle(1'b1, word_rot7);
    n_vec++;
    if (bus.locked !== 1'b1 || bus.bit_offset !== 5'd7) begin
      n_err++; $display("FAIL relock: locked=%b off=%0d want 1/7", bus.locked, bus.bit_offset);
    end
    cycle(1'b0, word_rot7);
    n_vec++;
    if (bus.locked !== 1'b0 || bus.sym_valid !== 1'b0 || bus.bit_offset !== 5'd0) begin
      n_err++; $display("FAIL rdy_drop: locked=%b sym_valid=%b off=%0d want 0/0/0", bus.locked, bus.sym_valid, bus.bit_offset);
    end
`ifdef TMDS_RX_STATS_EN
    n_vec++;
    if (bus.loss_count !== 16'd1) begin n_err++; $display("FAIL rdy_loss_count: got %0d want 1", bus.loss_count); end
`endif
  endtask

  task automatic test_wrap_and_relock();
    logic [19:0] seq[17];
    for (int i = 1; i <= 19 * SEARCH_CYCLES; i++) cycle(1'b1, WORD_DATA);
    n_vec++;
    if (bus.bit_offset !== 5'd19) begin n_err++; $display("FAIL wrap_reach19: off=%0d want 19", bus.bit_offset); end
    for (int i = 1; i <= SEARCH_CYCLES; i++) begin
      cycle(1'b1, WORD_DATA);
      if (i == SEARCH_CYCLES - 1) begin
        n_vec++;
        if (bus.bit_offset !== 5'd19) begin n_err++; $display("FAIL wrap_hold: off=%0d want 19", bus.bit_offset); end
      end
    end
    n_vec++;
    if (bus.bit_offset !== 5'd0) begin n_err++; $display("FAIL wrap_zero: off=%0d want 0", bus.bit_offset); end
    // Windows trail the driven word by one cycle at offset 0.
    for (int i = 0; i < 17; i++) seq[i] = (i == 7) ? WORD_DATA : WORD_ALIGNED;
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, seq[i-1]);
      if (i == 8 || i == 9 || i == 16) begin
        n_vec++;
        if (bus.locked !== 1'b0) begin n_err++; $display("FAIL broken_run: cycle %0d locked=%b want 0", i, bus.locked); end
      end
    end
    n_vec++;
    if (bus.locked !== 1'b1 || bus.bit_offset !== 5'd0) begin
      n_err++; $display("FAIL run_lock: locked=%b off=%0d want 1/0", bus.locked, bus.bit_offset);
    end
  endtask

  // ---------------- main ----------------
  initial begin
    logic [39:0] pp;
    pp = {WORD_ALIGNED, WORD_ALIGNED};
    word_rot7 = pp[32:13];
    test_reset();
    test_aligned();
    test_rotated();
    test_sparse_ctrl();
    test_loss();
    test_rx_ready_drop();
    test_wrap_and_relock();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
